// File: rtl/me_seq_pkg.sv
// Shared types and constants for the motion-estimation frame sequencer:
// FSM state encoding, address width and the 3x3 candidate neighbourhood.
package me_seq_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned NUM_CAND = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_XFER   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // Candidate j sits at (dx, dy) from the block, i.e. linear offset dy*GRID_W + dx
    localparam int CAND_DX [NUM_CAND] = '{-1,  0,  1, -1, 0, 1, -1, 0, 1};
    localparam int CAND_DY [NUM_CAND] = '{-1, -1, -1,  0, 0, 0,  1, 1, 1};

    function automatic logic cand_in_grid(input int x, input int y, input int j,
                                          input int w, input int h);
        int nx;
        int ny;
        nx = x + CAND_DX[j];
        ny = y + CAND_DY[j];
        return (nx >= 0) && (nx < w) && (ny >= 0) && (ny < h);
    endfunction

endpackage

// File: rtl/me_seq_addr_gen.sv
// Block walker for the search phase: row-major x/y counters, linear block
// address (8-bit, wraps) and, with SEQ_EDGE_MASK_EN, the in-grid candidate mask.
module me_seq_addr_gen
    import me_seq_pkg::*;
#(
    parameter int unsigned GRID_W = 5,
    parameter int unsigned GRID_H = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                adv,
    output logic [ADDR_W-1:0]   blk_addr_c,
    output logic                last_blk_c
`ifdef SEQ_EDGE_MASK_EN
    ,
    output logic [NUM_CAND-1:0] edge_mask_c
`endif
);

    localparam int unsigned X_W = $clog2(GRID_W);
    localparam int unsigned Y_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_last;

    assign x_last = (x_q == X_W'(GRID_W - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign blk_addr_c = ADDR_W'(int'(y_q) * int'(GRID_W) + int'(x_q));
    assign last_blk_c = x_last && (y_q == Y_W'(GRID_H - 1));

`ifdef SEQ_EDGE_MASK_EN
    always_comb begin
        edge_mask_c = '0;
        for (int j = 0; j < int'(NUM_CAND); j++) begin
            edge_mask_c[j] = cand_in_grid(int'(x_q), int'(y_q), j, int'(GRID_W), int'(GRID_H));
        end
    end
`endif

endmodule

// File: rtl/me_frame_sequencer.sv
// Frame sequencer: copies current frame A->B (reference), reloads A from the
// serial byte stream, then walks every block issuing read/calc/done pulses.
// Optional SEQ_EDGE_MASK_EN adds the edge_mask candidate-valid output.
module me_frame_sequencer
    import me_seq_pkg::*;
#(
    parameter int unsigned GRID_W         = 5,
    parameter int unsigned GRID_H         = 5,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_valid,
    output logic                busy,
    output logic                s2p_shift,
    output logic                a_csb0,
    output logic                a_web0,
    output logic [ADDR_W-1:0]   a_addr0,
    output logic                a_csb1,
    output logic [ADDR_W-1:0]   a_addr1,
    output logic                b_csb0,
    output logic                b_web0,
    output logic [ADDR_W-1:0]   b_addr0,
    output logic                calc_en,
    output logic                blk_done,
    output logic                frame_done
`ifdef SEQ_EDGE_MASK_EN
    ,
    output logic [NUM_CAND-1:0] edge_mask
`endif
);

    localparam int unsigned N     = GRID_W * GRID_H;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned BC_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
    logic               phase_q, phase_d;
    logic               drain_q, drain_d;

    logic               busy_q, busy_d;
    logic               a_csb0_q, a_csb0_d, a_web0_q, a_web0_d;
    logic [ADDR_W-1:0]  a_addr0_q, a_addr0_d;
    logic               a_csb1_q, a_csb1_d;
    logic [ADDR_W-1:0]  a_addr1_q, a_addr1_d;
    logic               b_csb0_q, b_csb0_d, b_web0_q, b_web0_d;
    logic [ADDR_W-1:0]  b_addr0_q, b_addr0_d;
    logic               calc_en_q, calc_en_d;
    logic               blk_done_q, blk_done_d;
    logic               frame_done_q, frame_done_d;

    logic               byte_last, word_last, xfer_end;
    logic               gen_clr, gen_adv;
    logic [ADDR_W-1:0]  blk_addr_c;
    logic               last_blk_c;
`ifdef SEQ_EDGE_MASK_EN
    logic [NUM_CAND-1:0] edge_mask_c;
    logic [NUM_CAND-1:0] edge_mask_q, edge_mask_d;
`endif

    // Byte capture follows s_valid combinationally so the s2p latches the present byte
    assign s2p_shift = s_valid && (state_q == ST_LOAD);

    assign byte_last = (byte_cnt_q == BC_W'(BYTES_PER_WORD - 1));
    assign word_last = (word_idx_q == ADDR_W'(N - 1));
    assign xfer_end  = (xfer_cnt_q == CNT_W'(N));
    assign gen_clr   = (state_q == ST_IDLE) && start;
    assign gen_adv   = (state_q == ST_SEARCH) && !drain_q && phase_q && !last_blk_c;

    me_seq_addr_gen #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (gen_clr),
        .adv        (gen_adv),
        .blk_addr_c (blk_addr_c),
        .last_blk_c (last_blk_c)
`ifdef SEQ_EDGE_MASK_EN
        ,
        .edge_mask_c(edge_mask_c)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            xfer_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            phase_q    <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            xfer_cnt_q <= xfer_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            phase_q    <= phase_d;
            drain_q    <= drain_d;
        end
    end

    // Next state; SEARCH holds one drain cycle so DONE lines up with the last blk_done
    always_comb begin
        state_d    = state_q;
        xfer_cnt_d = xfer_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        phase_d    = phase_q;
        drain_d    = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_XFER;
                    xfer_cnt_d = '0;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    phase_d    = 1'b0;
                    drain_d    = 1'b0;
                end
            end
            ST_XFER: begin
                xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
                if (xfer_end) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (s2p_shift) begin
                    if (byte_last) begin
                        byte_cnt_d = '0;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        if (word_last) state_d = ST_SEARCH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            ST_SEARCH: begin
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    phase_d = ~phase_q;
                    if (phase_q && last_blk_c) drain_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; every port below is registered, so it trails state_q by one cycle
    always_comb begin
        busy_d       = (state_q != ST_IDLE);
        a_csb0_d     = 1'b1;
        a_web0_d     = 1'b1;
        a_addr0_d    = a_addr0_q;
        a_csb1_d     = 1'b1;
        a_addr1_d    = a_addr1_q;
        b_csb0_d     = 1'b1;
        b_web0_d     = 1'b1;
        b_addr0_d    = b_addr0_q;
        calc_en_d    = 1'b0;
        blk_done_d   = calc_en_q;
        frame_done_d = 1'b0;
`ifdef SEQ_EDGE_MASK_EN
        edge_mask_d  = edge_mask_q;
`endif
        unique case (state_q)
            ST_XFER: begin
                if (xfer_cnt_q < CNT_W'(N)) begin
                    a_csb1_d  = 1'b0;
                    a_addr1_d = xfer_cnt_q[ADDR_W-1:0];
                end
                if (xfer_cnt_q != '0) begin
                    b_csb0_d  = 1'b0;
                    b_web0_d  = 1'b0;
                    b_addr0_d = ADDR_W'(xfer_cnt_q - CNT_W'(1));
                end
            end
            ST_LOAD: begin
                if (s2p_shift && byte_last) begin
                    a_csb0_d  = 1'b0;
                    a_web0_d  = 1'b0;
                    a_addr0_d = word_idx_q;
                end
            end
            ST_SEARCH: begin
                if (!drain_q) begin
                    if (!phase_q) begin
                        a_csb1_d  = 1'b0;
                        a_addr1_d = blk_addr_c;
                    end else begin
                        calc_en_d = 1'b1;
`ifdef SEQ_EDGE_MASK_EN
                        edge_mask_d = edge_mask_c;
`endif
                    end
                end
            end
            ST_DONE: frame_done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            a_csb0_q     <= 1'b1;
            a_web0_q     <= 1'b1;
            a_addr0_q    <= '0;
            a_csb1_q     <= 1'b1;
            a_addr1_q    <= '0;
            b_csb0_q     <= 1'b1;
            b_web0_q     <= 1'b1;
            b_addr0_q    <= '0;
            calc_en_q    <= 1'b0;
            blk_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SEQ_EDGE_MASK_EN
            edge_mask_q  <= '0;
`endif
        end else begin
            busy_q       <= busy_d;
            a_csb0_q     <= a_csb0_d;
            a_web0_q     <= a_web0_d;
            a_addr0_q    <= a_addr0_d;
            a_csb1_q     <= a_csb1_d;
            a_addr1_q    <= a_addr1_d;
            b_csb0_q     <= b_csb0_d;
            b_web0_q     <= b_web0_d;
            b_addr0_q    <= b_addr0_d;
            calc_en_q    <= calc_en_d;
            blk_done_q   <= blk_done_d;
            frame_done_q <= frame_done_d;
`ifdef SEQ_EDGE_MASK_EN
            edge_mask_q  <= edge_mask_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign a_csb0     = a_csb0_q;
    assign a_web0     = a_web0_q;
    assign a_addr0    = a_addr0_q;
    assign a_csb1     = a_csb1_q;
    assign a_addr1    = a_addr1_q;
    assign b_csb0     = b_csb0_q;
    assign b_web0     = b_web0_q;
    assign b_addr0    = b_addr0_q;
    assign calc_en    = calc_en_q;
    assign blk_done   = blk_done_q;
    assign frame_done = frame_done_q;
`ifdef SEQ_EDGE_MASK_EN
    assign edge_mask  = edge_mask_q;
`endif

endmodule

// File: tb/tb_me_frame_sequencer.sv
// Bench for me_frame_sequencer: logs every SRAM access and pulse per cycle,
// then checks each frame against a list-level model of the expected sequence.
module tb_me_frame_sequencer;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int BPW  = 4;
    localparam int N    = W * H;
    localparam int MAXC = 2000;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic start   = 1'b0;
    logic s_valid = 1'b0;
    logic busy, s2p_shift, a_csb0, a_web0, a_csb1, b_csb0, b_web0;
    logic calc_en, blk_done, frame_done;
    logic [7:0] a_addr0, a_addr1, b_addr0;
`ifdef SEQ_EDGE_MASK_EN
    logic [8:0] edge_mask;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    me_frame_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .busy      (busy),
        .s2p_shift (s2p_shift),
        .a_csb0    (a_csb0),
        .a_web0    (a_web0),
        .a_addr0   (a_addr0),
        .a_csb1    (a_csb1),
        .a_addr1   (a_addr1),
        .b_csb0    (b_csb0),
        .b_web0    (b_web0),
        .b_addr0   (b_addr0),
        .calc_en   (calc_en),
        .blk_done  (blk_done),
        .frame_done(frame_done)
`ifdef SEQ_EDGE_MASK_EN
        ,
        .edge_mask (edge_mask)
`endif
    );

    // Per-cycle event log
    int   cyc;
    logic sv_log   [0:MAXC-1];
    logic sh_log   [0:MAXC-1];
    logic busy_log [0:MAXC-1];
    int   rd_cyc[$], rd_adr[$], bw_cyc[$], bw_adr[$], aw_cyc[$], aw_adr[$];
    int   calc_cyc[$], bd_cyc[$], fd_cyc[$];
    logic [8:0] em_log[$];

    task automatic clear_log();
        cyc = 0;
        rd_cyc.delete(); rd_adr.delete(); bw_cyc.delete(); bw_adr.delete();
        aw_cyc.delete(); aw_adr.delete(); calc_cyc.delete(); bd_cyc.delete();
        fd_cyc.delete(); em_log.delete();
    endtask

    task automatic step(input logic st, input logic sv);
        @(posedge clk);
        #1;
        start   = st;
        s_valid = sv;
        @(negedge clk);
        if (cyc < MAXC) begin
            sv_log[cyc]   = sv;
            sh_log[cyc]   = s2p_shift;
            busy_log[cyc] = busy;
        end
        if (!a_csb1) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(a_addr1)); end
        if (!b_csb0 && !b_web0) begin bw_cyc.push_back(cyc); bw_adr.push_back(int'(b_addr0)); end
        if (!a_csb0 && !a_web0) begin aw_cyc.push_back(cyc); aw_adr.push_back(int'(a_addr0)); end
        if (calc_en) begin
            calc_cyc.push_back(cyc);
`ifdef SEQ_EDGE_MASK_EN
            em_log.push_back(edge_mask);
`endif
        end
        if (blk_done)   bd_cyc.push_back(cyc);
        if (frame_done) fd_cyc.push_back(cyc);
        cyc++;
    endtask

    // mode 0: s_valid always high, 1: every third cycle, 2: random
    task automatic run_frame(input int mode, input bit inject);
        bit   injected = 1'b0;
        int   tail = -1;
        logic sv, st;
        clear_log();
        step(1'b1, 1'b0);
        for (int i = 0; i < MAXC - 1; i++) begin
            case (mode)
                0:       sv = 1'b1;
                1:       sv = (cyc % 3 == 0);
                default: sv = 1'($urandom_range(0, 1));
            endcase
            st = 1'b0;
            if (inject && !injected && calc_cyc.size() == 3) begin
                st = 1'b1;
                injected = 1'b1;
            end
            step(st, sv);
            start = 1'b0;
            if (tail < 0 && fd_cyc.size() != 0) tail = 20;
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_por();
        logic [9:0] ctrl;
        #2 rst_n = 1'b0;
        #3;
        ctrl = {busy, s2p_shift, calc_en, blk_done, frame_done, a_csb0, a_web0, a_csb1, b_csb0, b_web0};
        total++;
        if (ctrl !== 10'b00000_11111) begin
            bad++; $display("FAIL por_ctrl got %b want %b", ctrl, 10'b00000_11111);
        end
        total++;
        if ({a_addr0, a_addr1, b_addr0} !== 24'h0) begin
            bad++; $display("FAIL por_addr got %h want 0", {a_addr0, a_addr1, b_addr0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 12; i++) step(1'b0, 1'($urandom_range(0, 1)));
        total++;
        if (rd_cyc.size() + bw_cyc.size() + aw_cyc.size() + calc_cyc.size() != 0) begin
            bad++; $display("FAIL por_idle_access got %0d want 0",
                            rd_cyc.size() + bw_cyc.size() + aw_cyc.size() + calc_cyc.size());
        end
    endtask

    task automatic test_full_frame(input int mode, input string tag);
        int   acc = 0, err = 0, first = -1, fd;
        int   acc_cyc[$];
        logic exp_sh;
        run_frame(mode, 1'b0);

        // Byte capture only inside LOAD: start takes one cycle, XFER lasts N+1
        for (int j = 0; j < cyc && j < MAXC; j++) begin
            exp_sh = sv_log[j] && (j >= N + 2) && (acc < N * BPW);
            if (exp_sh) begin acc_cyc.push_back(j); acc++; end
            if (sh_log[j] !== exp_sh) begin err++; if (first < 0) first = j; end
        end
        total++;
        if (err != 0) begin
            bad++; $display("FAIL %s s2p_shift cyc %0d got %b want %b", tag, first, sh_log[first], ~sh_log[first]);
        end

        total++;
        if (bw_cyc.size() != N) begin bad++; $display("FAIL %s b_write_count got %0d want %0d", tag, bw_cyc.size(), N); end
        total++;
        if (rd_cyc.size() != 2 * N) begin bad++; $display("FAIL %s a_read_count got %0d want %0d", tag, rd_cyc.size(), 2 * N); end
        if (bw_cyc.size() == N && rd_cyc.size() == 2 * N) begin
            err = 0; first = -1;
            for (int k = 0; k < N; k++)
                if (rd_adr[k] != k || bw_adr[k] != k || bw_cyc[k] != rd_cyc[k] + 1 ||
                    rd_cyc[k] != rd_cyc[0] + k) begin err++; if (first < 0) first = k; end
            total++;
            if (err != 0) begin
                bad++; $display("FAIL %s xfer word %0d got rd=%0d wr=%0d want %0d", tag, first, rd_adr[first], bw_adr[first], first);
            end
        end

        total++;
        if (aw_cyc.size() != N) begin bad++; $display("FAIL %s a_write_count got %0d want %0d", tag, aw_cyc.size(), N); end
        if (aw_cyc.size() == N && acc == N * BPW) begin
            err = 0; first = -1;
            for (int m = 0; m < N; m++)
                if (aw_adr[m] != m || aw_cyc[m] != acc_cyc[BPW * m + BPW - 1] + 1) begin
                    err++; if (first < 0) first = m;
                end
            total++;
            if (err != 0) begin
                bad++; $display("FAIL %s a_write word %0d got addr %0d cyc %0d want addr %0d cyc %0d", tag, first,
                                aw_adr[first], aw_cyc[first], first, acc_cyc[BPW * first + BPW - 1] + 1);
            end
        end

        total++;
        if (calc_cyc.size() != N || bd_cyc.size() != N) begin
            bad++; $display("FAIL %s calc_blk_count got %0d/%0d want %0d", tag, calc_cyc.size(), bd_cyc.size(), N);
        end
        if (rd_cyc.size() == 2 * N && calc_cyc.size() == N && bd_cyc.size() == N && aw_cyc.size() == N) begin
            err = 0; first = -1;
            for (int i = 0; i < N; i++)
                if (rd_adr[N + i] != i || calc_cyc[i] != rd_cyc[N + i] + 1 || bd_cyc[i] != calc_cyc[i] + 1 ||
                    (i > 0 && rd_cyc[N + i] != rd_cyc[N + i - 1] + 2)) begin err++; if (first < 0) first = i; end
            total++;
            if (err != 0) begin
                bad++; $display("FAIL %s search blk %0d got addr %0d want %0d", tag, first, rd_adr[N + first], first);
            end
            total++;
            if (rd_cyc[N] <= aw_cyc[N - 1]) begin
                bad++; $display("FAIL %s search_after_load got %0d want >%0d", tag, rd_cyc[N], aw_cyc[N - 1]);
            end
        end

        total++;
        if (fd_cyc.size() != 1) begin
            bad++; $display("FAIL %s frame_done_count got %0d want 1", tag, fd_cyc.size());
        end else if (bd_cyc.size() == N) begin
            fd = fd_cyc[0];
            total++;
            if (fd != bd_cyc[N - 1] + 1) begin
                bad++; $display("FAIL %s frame_done_cyc got %0d want %0d", tag, fd, bd_cyc[N - 1] + 1);
            end
            total++;
            if (busy_log[fd] !== 1'b1 || busy_log[fd + 1] !== 1'b0) begin
                bad++; $display("FAIL %s busy_at_done got %b%b want 10", tag, busy_log[fd], busy_log[fd + 1]);
            end
        end

`ifdef SEQ_EDGE_MASK_EN
        if (em_log.size() == N) begin
            logic [8:0] exp_m;
            int x, y;
            err = 0; first = -1;
            for (int i = 0; i < N; i++) begin
                x = i % W; y = i / W; exp_m = '0;
                for (int j = 0; j < 9; j++)
                    if (x + j % 3 - 1 >= 0 && x + j % 3 - 1 < W && y + j / 3 - 1 >= 0 && y + j / 3 - 1 < H)
                        exp_m[j] = 1'b1;
                if (em_log[i] !== exp_m) begin err++; if (first < 0) first = i; end
            end
            total++;
            if (err != 0) begin bad++; $display("FAIL %s edge_mask blk %0d got %b", tag, first, em_log[first]); end
            total++;
            if (em_log[0] !== 9'b110110000) begin bad++; $display("FAIL %s edge_mask_00 got %b want 110110000", tag, em_log[0]); end
            total++;
            if (em_log[N - 1] !== 9'b000011011) begin bad++; $display("FAIL %s edge_mask_44 got %b want 000011011", tag, em_log[N - 1]); end
            total++;
            if (em_log[12] !== 9'h1FF) begin bad++; $display("FAIL %s edge_mask_22 got %b want 111111111", tag, em_log[12]); end
        end else begin
            total++; bad++;
            $display("FAIL %s edge_mask_count got %0d want %0d", tag, em_log.size(), N);
        end
`endif
    endtask

    task automatic test_start_ignored();
        run_frame(0, 1'b1);
        total++;
        if (fd_cyc.size() != 1) begin bad++; $display("FAIL start_ign frame_done_count got %0d want 1", fd_cyc.size()); end
        total++;
        if (calc_cyc.size() != N) begin bad++; $display("FAIL start_ign calc_count got %0d want %0d", calc_cyc.size(), N); end
        total++;
        if (bw_cyc.size() != N || aw_cyc.size() != N) begin
            bad++; $display("FAIL start_ign write_count got %0d/%0d want %0d", bw_cyc.size(), aw_cyc.size(), N);
        end
        total++;
        if (busy_log[cyc - 1] !== 1'b0) begin bad++; $display("FAIL start_ign busy_end got %b want 0", busy_log[cyc - 1]); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] ctrl;
        clear_log();
        step(1'b1, 1'b0);
        for (int i = 0; i < 400 && aw_cyc.size() < 3; i++) step(1'b0, 1'b1);
        total++;
        if (aw_cyc.size() != 3) begin bad++; $display("FAIL rst_mid reach_word3 got %0d want 3", aw_cyc.size()); end
        #2 rst_n = 1'b0;
        #1;
        ctrl = {busy, s2p_shift, calc_en, blk_done, frame_done, a_csb0, a_web0, a_csb1, b_csb0, b_web0};
        total++;
        if (ctrl !== 10'b00000_11111) begin
            bad++; $display("FAIL rst_mid_ctrl got %b want %b", ctrl, 10'b00000_11111);
        end
        total++;
        if ({a_addr0, a_addr1, b_addr0} !== 24'h0) begin
            bad++; $display("FAIL rst_mid_addr got %h want 0", {a_addr0, a_addr1, b_addr0});
        end
`ifdef SEQ_EDGE_MASK_EN
        total++;
        if (edge_mask !== 9'h0) begin bad++; $display("FAIL rst_mid_mask got %b want 0", edge_mask); end
`endif
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 12; i++) step(1'b0, 1'($urandom_range(0, 1)));
        total++;
        if (rd_cyc.size() + bw_cyc.size() + aw_cyc.size() != 0) begin
            bad++; $display("FAIL rst_mid_idle_access got %0d want 0", rd_cyc.size() + bw_cyc.size() + aw_cyc.size());
        end
        total++;
        if (busy_log[11] !== 1'b0 || sh_log[11] !== 1'b0) begin
            bad++; $display("FAIL rst_mid_idle_busy got %b%b want 00", busy_log[11], sh_log[11]);
        end
        test_full_frame(2, "restart");
    endtask

    initial begin
        test_reset_por();
        test_full_frame(0, "contig");
        test_full_frame(1, "every3");
        test_full_frame(2, "random");
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
